// File: rtl/multicycle_control_if.sv
// Control-unit bus: opcode/memory handshake in, datapath controls and debug state out.
// Ports: opcode, mem_ready (to controller); PCWrite..RegDst, instr_done, illegal_op,
//        instr_count, state (from controller). master = controller, slave = datapath side.
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             MemtoReg;
    logic             IRWrite;
    logic [1:0]       PCSource;
    logic [1:0]       ALUop;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic             RegWrite;
    logic             RegDst;
    logic             instr_done;
    logic             illegal_op;
    logic [CNT_W-1:0] instr_count;
    logic [3:0]       state;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               PCSource, ALUop, ALUSrcA, ALUSrcB, RegWrite, RegDst,
               instr_done, illegal_op, instr_count, state
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               PCSource, ALUop, ALUSrcA, ALUSrcB, RegWrite, RegDst,
               instr_done, illegal_op, instr_count, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath (fetch/decode/exec/mem/writeback).
// Latency: lw 5, sw/R/addi 4, beq/j 3 cycles, plus one per mem_ready=0 cycle in FETCH/MEM_RD/MEM_WR.
// Backpressure: holds FETCH/MEM_RD/MEM_WR until mem_ready; ports clk, rst_n, bus (master modport).
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC     = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] count_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unused codes 12-15 fall to the default and recover to FETCH
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_R:         state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDI_EX;
                    default:      state_d = FETCH;
                endcase
            end
            MEM_ADDR: state_d = (bus.opcode == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:   state_d = bus.mem_ready ? MEM_WB : MEM_RD;
            MEM_WB:   state_d = FETCH;
            MEM_WR:   state_d = bus.mem_ready ? FETCH : MEM_WR;
            EXEC:     state_d = R_WB;
            R_WB:     state_d = FETCH;
            BRANCH:   state_d = FETCH;
            JUMP:     state_d = FETCH;
            ADDI_EX:  state_d = ADDI_WB;
            ADDI_WB:  state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    // Output decode: Moore except the FETCH write enables, sw completion and illegal_op
    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.PCSource    = 2'b00;
        bus.ALUop       = 2'b00;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.RegWrite    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.instr_done  = 1'b0;
        bus.illegal_op  = 1'b0;
        case (state_q)
            FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
            end
            DECODE: begin
                bus.ALUSrcB = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW, OP_R, OP_BEQ, OP_J, OP_ADDI: bus.illegal_op = 1'b0;
                    default:                                   bus.illegal_op = 1'b1;
                endcase
            end
            MEM_ADDR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            MEM_RD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            MEM_WB: begin
                bus.RegWrite   = 1'b1;
                bus.MemtoReg   = 1'b1;
                bus.instr_done = 1'b1;
            end
            MEM_WR: begin
                bus.MemWrite   = 1'b1;
                bus.IorD       = 1'b1;
                bus.instr_done = bus.mem_ready;
            end
            EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUop   = 2'b10;
            end
            R_WB: begin
                bus.RegWrite   = 1'b1;
                bus.RegDst     = 1'b1;
                bus.instr_done = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUop       = 2'b01;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
                bus.instr_done  = 1'b1;
            end
            JUMP: begin
                bus.PCWrite    = 1'b1;
                bus.PCSource   = 2'b10;
                bus.instr_done = 1'b1;
            end
            ADDI_EX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            ADDI_WB: begin
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
            end
            default: begin
                bus.instr_done = 1'b0;
            end
        endcase
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (bus.instr_done) begin
            count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.instr_count = count_q;
    assign bus.state       = state_q;
endmodule
